// File: rtl/seq_pkg.sv
// seq_pkg: shared types for the stage sequencer.
//   - RISC-V major opcode constants
//   - state_t    : sequencer FSM states
//   - iclass_t   : instruction classes produced by the opcode classifier
//   - stage_mask_t: one bit per datapath stage, [0]=S1 [1]=S2_1 [2]=S2_2 [3]=S3 [4]=S4
//   - next_stage : picks the next used stage after the current one
package seq_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2_1,
    ST_S2_2,
    ST_S3,
    ST_S4
  } state_t;

  typedef enum logic [2:0] {
    IC_R,
    IC_IMM,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_JUMP,
    IC_UPPER,
    IC_ILLEGAL
  } iclass_t;

  typedef logic [4:0] stage_mask_t;

  // Only the stages after S1 matter here: every legal class starts with S1.
  function automatic state_t next_stage(state_t cur, logic [4:1] later);
    state_t nxt;
    nxt = ST_IDLE;
    case (cur)
      ST_S1: begin
        if      (later[1]) nxt = ST_S2_1;
        else if (later[2]) nxt = ST_S2_2;
        else if (later[3]) nxt = ST_S3;
        else if (later[4]) nxt = ST_S4;
      end
      ST_S2_1: begin
        if      (later[2]) nxt = ST_S2_2;
        else if (later[3]) nxt = ST_S3;
        else if (later[4]) nxt = ST_S4;
      end
      ST_S2_2: begin
        if      (later[3]) nxt = ST_S3;
        else if (later[4]) nxt = ST_S4;
      end
      ST_S3: begin
        if (later[4]) nxt = ST_S4;
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stage_sequencer_classifier.sv
// opcode_classifier: purely combinational decode of a 7-bit RISC-V opcode.
// Ports:
//   opcode_i  in  7  opcode field
//   iclass_o  out    instruction class (IC_ILLEGAL for unknown opcodes)
//   mask_o    out 5  stages the class uses
//   illegal_o out 1  opcode is not one of the supported major opcodes
module opcode_classifier
  import seq_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output iclass_t     iclass_o,
  output stage_mask_t mask_o,
  output logic        illegal_o
);

  always_comb begin
    iclass_o  = IC_ILLEGAL;
    mask_o    = 5'b00000;
    illegal_o = 1'b1;
    case (opcode_i)
      OP_R:      begin iclass_o = IC_R;      mask_o = 5'b01111; illegal_o = 1'b0; end
      OP_BRANCH: begin iclass_o = IC_BRANCH; mask_o = 5'b01111; illegal_o = 1'b0; end
      OP_IMM:    begin iclass_o = IC_IMM;    mask_o = 5'b01011; illegal_o = 1'b0; end
      OP_JALR:   begin iclass_o = IC_JUMP;   mask_o = 5'b01011; illegal_o = 1'b0; end
      OP_LOAD:   begin iclass_o = IC_LOAD;   mask_o = 5'b11011; illegal_o = 1'b0; end
      OP_STORE:  begin iclass_o = IC_STORE;  mask_o = 5'b11111; illegal_o = 1'b0; end
      OP_JAL:    begin iclass_o = IC_JUMP;   mask_o = 5'b01001; illegal_o = 1'b0; end
      OP_LUI:    begin iclass_o = IC_UPPER;  mask_o = 5'b01001; illegal_o = 1'b0; end
      OP_AUIPC:  begin iclass_o = IC_UPPER;  mask_o = 5'b01001; illegal_o = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: steps one instruction through the 5-stage datapath,
// raising one stage request at a time and holding it until that stage acks.
// Optional feature macro: SEQ_TIMEOUT_EN (per-stage ack timeout -> err).
// Ports:
//   clk, reset                 clock / async active-high reset
//   set, opcode[6:0]           start strobe and opcode, sampled in IDLE
//   ack1 ack2_1 ack2_2 ack3 ack4   stage acknowledges
//   req1 req2_1 req2_2 req3 req4   stage requests (decoded from state)
//   busy                       sequence in progress
//   done                       one-cycle pulse after the last stage acks
//   err                        one-cycle pulse on illegal opcode or timeout
//   retired[RETIRE_W-1:0]      wrapping count of done pulses
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set,
  input  logic [6:0]          opcode,
  input  logic                ack1,
  input  logic                ack2_1,
  input  logic                ack2_2,
  input  logic                ack3,
  input  logic                ack4,
  output logic                req1,
  output logic                req2_1,
  output logic                req2_2,
  output logic                req3,
  output logic                req4,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [RETIRE_W-1:0] retired
);

  state_t                state_q;
  logic [6:0]            opcode_q;
  logic                  done_q;
  logic                  err_q;
  logic [RETIRE_W-1:0]   retired_q;

  logic [6:0]            cls_op_d;
  iclass_t               cls_iclass;
  stage_mask_t           cls_mask;
  logic                  cls_illegal;
  logic                  illegal_d;
  logic                  ack_cur_d;
  state_t                nxt_state_d;

  // In IDLE the live opcode is decoded so illegal opcodes are caught on set;
  // during a sequence the latched opcode supplies the stage list.
  assign cls_op_d = (state_q == ST_IDLE) ? opcode : opcode_q;

  opcode_classifier u_cls (
    .opcode_i  (cls_op_d),
    .iclass_o  (cls_iclass),
    .mask_o    (cls_mask),
    .illegal_o (cls_illegal)
  );

  // A class/illegal disagreement is treated as illegal.
  assign illegal_d = cls_illegal | (cls_iclass == IC_ILLEGAL);

  always_comb begin
    ack_cur_d = 1'b0;
    case (state_q)
      ST_S1:   ack_cur_d = ack1;
      ST_S2_1: ack_cur_d = ack2_1;
      ST_S2_2: ack_cur_d = ack2_2;
      ST_S3:   ack_cur_d = ack3;
      ST_S4:   ack_cur_d = ack4;
      default: ack_cur_d = 1'b0;
    endcase
  end

  assign nxt_state_d = next_stage(state_q, cls_mask[4:1]);

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 7'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      // Cleared by default so every state entry starts a fresh wait.
      wait_q <= '0;
`endif
      if (state_q == ST_IDLE) begin
        if (set) begin
          if (illegal_d) begin
            err_q <= 1'b1;
          end else begin
            state_q  <= ST_S1;
            opcode_q <= opcode;
          end
        end
      end else if (ack_cur_d) begin
        state_q <= nxt_state_d;
        if (nxt_state_d == ST_IDLE) begin
          done_q    <= 1'b1;
          retired_q <= retired_q + 1'b1;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      // wait_q counts completed wait cycles; the req has been up
      // TIMEOUT_CYCLES cycles when this edge sees TIMEOUT_CYCLES-1.
      else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
      end else begin
        wait_q <= wait_q + 1'b1;
      end
`endif
    end
  end

  assign req1    = (state_q == ST_S1);
  assign req2_1  = (state_q == ST_S2_1);
  assign req2_2  = (state_q == ST_S2_2);
  assign req3    = (state_q == ST_S3);
  assign req4    = (state_q == ST_S4);
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule
